instruction_dispatcher: RTL and testbench
=========================================

// Module: instruction_dispatcher
// PURPOSE
//   Consumer stage of the 13-bit instruction FIFO; drives the FIFO read enable.
//   Pops one instruction at a time, decodes opcode/address/length, and issues
//   len+1 command beats to the compute datapath over a valid/ready handshake.
//   Handles NOP, SYNC (wait for datapath done) and HALT (stop fetching until start).
// PARAMETERS
//   INSTR_W  13  instruction width; fixed format [12:10] op, [9:5] addr, [4:0] len
//   ADDR_W   5   address field and cmd_addr width
//   LEN_W    5   length field width; beats per instruction = len+1 (1..32)
//   CNT_W    16  retired-instruction counter width
// PORTS
//   clk          in   1        clock, all state updates on rising edge
//   rst          in   1        asynchronous, active-low reset
//   start        in   1        1-cycle pulse; leaves IDLE (halted) and begins fetching
//   fifo_data    in   INSTR_W  FIFO read data; valid the cycle after fifo_rd_en
//   fifo_empty   in   1        FIFO empty flag
//   fifo_rd_en   out  1        FIFO pop request
//   cmd_valid    out  1        command beat valid
//   cmd_ready    in   1        datapath accepts beat when cmd_valid && cmd_ready
//   cmd_op       out  3        opcode of current beat
//   cmd_addr     out  ADDR_W   beat address (base + beat index, mod 2^ADDR_W)
//   cmd_last     out  1        high on final beat of an instruction
//   done_in      in   1        datapath completion pulse, used by SYNC
//   halted       out  1        high in IDLE
//   instr_count  out  CNT_W    retired instructions, saturating
// BEHAVIOUR
//   Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 MATMUL, 4 ADD, 5 ACT, 6 SYNC, 7 HALT.
//   Reset (rst=0, async): state IDLE; halted=1; fifo_rd_en, cmd_valid, cmd_last=0;
//     cmd_op, cmd_addr, instr_count=0; internal instr/beat registers cleared.
//   States: IDLE, FETCH, LATCH, ISSUE, SYNC.
//   IDLE: halted=1; start -> FETCH. start ignored in all other states.
//   FETCH: fifo_rd_en = !fifo_empty (combinational from state); if popped -> LATCH,
//     else stay. fifo_rd_en never high outside FETCH, never high when fifo_empty.
//   LATCH: register fifo_data; beat=0; addr=instr[9:5]. Next by opcode:
//     NOP -> FETCH, retire; SYNC -> SYNC; HALT -> IDLE, retire; 1..5 -> ISSUE.
//   ISSUE: cmd_valid=1; cmd_op/cmd_addr/cmd_last held stable while !cmd_ready.
//     On handshake: beat++, addr++ (wraps 31->0); if cmd_last -> FETCH, retire.
//     cmd_last = (beat == len); len=0 gives a single beat with cmd_last=1.
//   SYNC: wait for done_in=1 (sampled, level) -> FETCH, retire. done_in ignored elsewhere.
//   Latency: fifo_rd_en cycle N -> data latched end of N+1 -> cmd_valid at N+2.
//   Back-to-back: after last handshake, FETCH next cycle; min 3 cycles between
//     the last beat of one instruction and the first beat of the next.
//   instr_count increments once per retired instruction; saturates at 2^CNT_W-1.
//   Reset mid-ISSUE/SYNC: instruction abandoned, no further beats, returns to IDLE;
//     any popped instruction is lost (upstream FIFO resets with the same reset).
//   cmd_valid is registered; cmd_valid never drops without a handshake or reset.
// TESTING
//   Reset, start, FIFO empty -> stays FETCH, fifo_rd_en=0, cmd_valid=0, halted=0.
//   Push 0x0464 (LOAD addr=3 len=4), cmd_ready=1 -> 5 beats addr 3..7, cmd_last on
//     addr 7, cmd_valid 2 cycles after fifo_rd_en, instr_count=1.
//   MATMUL addr=30 len=3 with cmd_ready toggling 1/0 -> addrs 30,31,0,1; outputs
//     stable during stalls; exactly 4 handshakes.
//   Stream NOP, SYNC, ADD len=0, HALT -> no beat for NOP; ADD waits until done_in
//     pulse; single ADD beat with cmd_last=1; then halted=1, no further pops, count=4.
//   Assert rst=0 mid-ISSUE (beat 2 of 5) -> cmd_valid=0 immediately, halted=1,
//     instr_count=0; after start, next FIFO instruction issues from beat 0.
//   Force instr_count to max-1, retire 3 NOPs -> count saturates at 0xFFFF.

Source files
------------

// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: pops 13-bit instructions from the upstream FIFO, decodes
// them and issues len+1 command beats to the compute datapath; handles NOP/SYNC/HALT.
module instruction_dispatcher #(
  parameter int INSTR_W = 13,
  parameter int ADDR_W  = 5,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INSTR_W-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [2:0]         cmd_op,
  output logic [ADDR_W-1:0]  cmd_addr,
  output logic               cmd_last,
  input  logic               done_in,
  output logic               halted,
  output logic [CNT_W-1:0]   instr_count,
  output logic [2:0]         dbg_state
);

  // Handshake: a beat transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_valid is registered and, once high, stays high with op/addr/last frozen
  // until that transfer happens (or reset).

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_SYNC  = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SYNC = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t state, state_next;

  logic [2:0]       dec_op;
  logic [ADDR_W-1:0] dec_addr;
  logic [LEN_W-1:0] dec_len;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic             handshake;
  logic             retire;

  assign dec_op   = fifo_data[INSTR_W-1 -: 3];
  assign dec_addr = fifo_data[LEN_W +: ADDR_W];
  assign dec_len  = fifo_data[LEN_W-1:0];

  assign handshake = cmd_valid && cmd_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: if (!fifo_empty) state_next = S_LATCH;
      S_LATCH: begin
        case (dec_op)
          OP_NOP:  state_next = S_FETCH;
          OP_SYNC: state_next = S_SYNC;
          OP_HALT: state_next = S_IDLE;
          default: state_next = S_ISSUE;
        endcase
      end
      S_ISSUE: if (handshake && cmd_last) state_next = S_FETCH;
      S_SYNC:  if (done_in) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE:  halted = 1'b1;
      S_FETCH: fifo_rd_en = !fifo_empty;
      S_LATCH: retire = (dec_op == OP_NOP) || (dec_op == OP_HALT);
      S_ISSUE: retire = handshake && cmd_last;
      S_SYNC:  retire = done_in;
      default: halted = 1'b0;
    endcase
  end

  // Beat registers: loaded from the FIFO word in LATCH, stepped on each transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      beat_q    <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      cmd_last  <= 1'b0;
    end else begin
      case (state)
        S_LATCH: begin
          len_q     <= dec_len;
          beat_q    <= '0;
          cmd_op    <= dec_op;
          cmd_addr  <= dec_addr;
          cmd_last  <= (dec_len == '0);
          cmd_valid <= (dec_op != OP_NOP) && (dec_op != OP_SYNC) && (dec_op != OP_HALT);
        end
        S_ISSUE: begin
          if (handshake) begin
            if (cmd_last) begin
              cmd_valid <= 1'b0;
            end else begin
              beat_q   <= beat_q + LEN_W'(1);
              cmd_addr <= cmd_addr + ADDR_W'(1);
              cmd_last <= ((beat_q + LEN_W'(1)) == len_q);
            end
          end
        end
        default: cmd_valid <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
    end else if (retire && (instr_count != '1)) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: FIFO model, beat scoreboard, stall/latency
// monitors, and a narrow-counter instance for saturation.
module tb_instruction_dispatcher;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [12:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic        cmd_last;
  logic        done_in = 1'b0;
  logic        halted;
  logic [15:0] instr_count;
  logic [2:0]  dbg_state;

  logic        sat_start = 1'b0;
  logic [12:0] sat_data = '0;
  logic        sat_empty;
  logic        sat_rd_en;
  logic        sat_valid;
  logic [2:0]  sat_op;
  logic [4:0]  sat_addr;
  logic        sat_last;
  logic        sat_halted;
  logic [3:0]  sat_count;
  logic [2:0]  sat_state;

  always #5 clk = ~clk;

  instruction_dispatcher dut (
    .clk(clk), .rst(rst), .start(start),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_last(cmd_last), .done_in(done_in),
    .halted(halted), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  instruction_dispatcher #(.CNT_W(4)) sat_dut (
    .clk(clk), .rst(rst), .start(sat_start),
    .fifo_data(sat_data), .fifo_empty(sat_empty), .fifo_rd_en(sat_rd_en),
    .cmd_valid(sat_valid), .cmd_ready(1'b1), .cmd_op(sat_op),
    .cmd_addr(sat_addr), .cmd_last(sat_last), .done_in(1'b0),
    .halted(sat_halted), .instr_count(sat_count), .dbg_state(sat_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_pop_cyc = 0;
  int exp_count = 0;
  int ready_mode = 0;

  logic [8:0]  exp_q[$];
  logic [12:0] fifo_q[$];
  int          fifo_cnt = 0;
  int          sat_cnt = 0;
  logic        pop_seen = 1'b0;
  logic        sat_seen = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [9:0]  prev_vec = '0;

  assign fifo_empty = (fifo_cnt == 0);
  assign sat_empty  = (sat_cnt == 0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // cmd_ready pattern: 0 = always ready, 1 = toggling, 2 = never ready
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       cmd_ready = ~cmd_ready;
      2:       cmd_ready = 1'b0;
      default: cmd_ready = 1'b1;
    endcase
  end

  // FIFO models: a pop seen at one negedge delivers data by the following negedge
  always @(negedge clk) begin
    if (!rst) begin
      pop_seen = 1'b0;
      sat_seen = 1'b0;
    end else begin
      if (pop_seen && fifo_q.size() != 0) begin
        fifo_data = fifo_q.pop_front();
        fifo_cnt--;
      end
      pop_seen = fifo_rd_en;
      if (sat_seen && sat_cnt > 0) sat_cnt--;
      sat_seen = sat_rd_en;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      logic [8:0] exp_beat;
      check("rd_en_guard", {31'd0, fifo_rd_en & fifo_empty}, 0);
      if (cmd_valid && !prev_valid) check("valid_latency", cyc - last_pop_cyc, 2);
      if (prev_stall)
        check("stall_hold", {22'd0, cmd_valid, cmd_op, cmd_addr, cmd_last}, {22'd0, prev_vec});
      if (fifo_rd_en) last_pop_cyc = cyc;
      if (cmd_valid && cmd_ready) begin
        hs_count++;
        check("beat_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check("beat", {23'd0, cmd_op, cmd_addr, cmd_last}, {23'd0, exp_beat});
        end
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_vec   = {cmd_valid, cmd_op, cmd_addr, cmd_last};
      prev_valid = cmd_valid;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_instr(input logic [2:0] op, input logic [4:0] addr, input logic [4:0] len);
    logic [4:0] a;
    fifo_q.push_back({op, addr, len});
    fifo_cnt++;
    if (op >= 3'd1 && op <= 3'd5) begin
      for (int i = 0; i <= int'(len); i++) begin
        a = addr + 5'(i);
        exp_q.push_back({op, a, i == int'(len)});
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_state", {29'd0, dbg_state}, {29'd0, s});
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_hs", hs_count, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    tick(3);
    check("rst_halted", {31'd0, halted}, 1);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    check("rst_valid", {31'd0, cmd_valid}, 0);
    check("rst_last", {31'd0, cmd_last}, 0);
    check("rst_op_addr", {24'd0, cmd_op, cmd_addr}, 0);
    check("rst_count", {16'd0, instr_count}, 0);
    rst = 1'b1;
    tick(1);
    pulse_start();
    tick(5);
    check("empty_state", {29'd0, dbg_state}, {29'd0, ST_FETCH});
    check("empty_rd_en", {31'd0, fifo_rd_en}, 0);
    check("empty_valid", {31'd0, cmd_valid}, 0);
    check("empty_halted", {31'd0, halted}, 0);

    // LOAD addr=3 len=4 (0x0464)
    push_instr(3'd1, 5'd3, 5'd4);
    exp_count++;
    wait_hs(5, 40);
    tick(2);
    check("load_count", {16'd0, instr_count}, exp_count);
    check("load_drained", exp_q.size(), 0);

    // MATMUL addr=30 len=3 with toggling ready: address wrap and stall hold
    ready_mode = 1;
    base = hs_count;
    push_instr(3'd3, 5'd30, 5'd3);
    exp_count++;
    wait_hs(base + 4, 60);
    tick(4);
    check("mm_handshakes", hs_count, base + 4);
    check("mm_count", {16'd0, instr_count}, exp_count);
    ready_mode = 0;

    // NOP, SYNC, ADD len=0, HALT
    base = hs_count;
    push_instr(3'd0, 5'd0, 5'd0);
    push_instr(3'd6, 5'd0, 5'd0);
    push_instr(3'd4, 5'd9, 5'd0);
    push_instr(3'd7, 5'd0, 5'd0);
    wait_state(ST_SYNC, 40);
    tick(6);
    check("sync_no_beat", hs_count, base);
    check("sync_count", {16'd0, instr_count}, exp_count + 1);
    done_in = 1'b1;
    tick(1);
    done_in = 1'b0;
    exp_count += 4;
    wait_state(ST_IDLE, 40);
    check("halt_beats", hs_count, base + 1);
    check("halt_count", {16'd0, instr_count}, exp_count);
    check("halt_halted", {31'd0, halted}, 1);

    // Halted: a queued instruction must not be popped
    push_instr(3'd1, 5'd0, 5'd4);
    tick(6);
    check("halt_no_pop", fifo_cnt, 1);
    check("halt_stays", {29'd0, dbg_state}, {29'd0, ST_IDLE});

    // Reset while beat 2 of 5 is presented
    pulse_start();
    base = hs_count;
    wait_hs(base + 2, 40);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, cmd_valid}, 0);
    check("mid_rst_halted", {31'd0, halted}, 1);
    check("mid_rst_count", {16'd0, instr_count}, 0);
    exp_q.delete();
    fifo_q.delete();
    fifo_cnt = 0;
    exp_count = 0;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("post_rst_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    push_instr(3'd1, 5'd10, 5'd2);
    exp_count++;
    pulse_start();
    base = hs_count;
    wait_hs(base + 3, 40);
    tick(2);
    check("post_rst_count", {16'd0, instr_count}, exp_count);
    check("post_rst_drained", exp_q.size(), 0);

    // Saturation on a 4-bit counter instance: 20 NOPs -> 15
    sat_cnt = 20;
    sat_start = 1'b1;
    tick(1);
    sat_start = 1'b0;
    n = 0;
    while (sat_cnt != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("sat_drained", sat_cnt, 0);
    tick(4);
    check("sat_count", {28'd0, sat_count}, 32'd15);
    check("sat_not_halted", {31'd0, sat_halted}, 0);
    check("sat_no_beats", {31'd0, sat_valid}, 0);

    check("final_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
